// File: rtl/rv_dmem_subsys.sv
// rv_dmem_subsys: M-stage data memory for the pipelined RV32I core.
// Contains a byte-enabled synchronous RAM whose read latency is a parameter,
// sign/zero-extended loads, and a small word-only MMIO window (LED register,
// free-running cycle counter, error status). Illegal or misaligned accesses
// are suppressed and reported.
module rv_dmem_subsys #(
    parameter int          ADDR_W    = 10,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int          LED_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemReadM_i,
    input  logic             MemWriteM_i,
    input  logic [2:0]       Funct3M_i,
    input  logic [31:0]      ALUResultM_i,
    input  logic [31:0]      WriteDataM_i,
    output logic [31:0]      ReadDataM_o,
    output logic             StallM_o,
    output logic [LED_W-1:0] led_o,
    output logic             err_o
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        cnt;
    logic [1:0]        cnt_next;
    logic              stall;

    logic [1:0]        size;
    logic              is_mmio;
    logic              req;
    logic              f3_legal;
    logic              misaligned;
    logic              sub_word;
    logic              bad_access;
    logic              good_access;
    logic              ram_load;
    logic              ram_store;
    logic              mmio_load;
    logic              mmio_store;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] ram_idx;
    logic [31:0]       store_data;
    logic [3:0]        byte_en;
    logic [31:0]       rd_pipe [RD_LAT];
    logic [31:0]       hold;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;

    logic [31:0]       mmio_off;
    logic [31:0]       mmio_rdata;
    logic [LED_W-1:0]  led_q;
    logic [31:0]       cycle_q;
    logic              sticky_q;
    logic [7:0]        miscount_q;

    assign size     = Funct3M_i[1:0];
    assign is_mmio  = (ALUResultM_i >= MMIO_BASE);
    assign req      = MemReadM_i | MemWriteM_i;
    assign ram_idx  = ALUResultM_i[ADDR_W-1:2];
    assign mmio_off = ALUResultM_i - MMIO_BASE;
    assign hold     = rd_pipe[RD_LAT-1];
    assign led_o    = led_q;

    // Legality of funct3 depends on whether the request is a load or a store
    always_comb begin
        f3_legal = 1'b0;
        if (MemReadM_i) begin
            case (Funct3M_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else if (MemWriteM_i) begin
            case (Funct3M_i)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end
    end

    // Classify the request; a bad access is suppressed everywhere below
    always_comb begin
        misaligned  = ((size == 2'b01) && ALUResultM_i[0]) ||
                      ((size == 2'b10) && (ALUResultM_i[1:0] != 2'b00));
        sub_word    = is_mmio && (size != 2'b10);
        bad_access  = req && ((MemReadM_i && MemWriteM_i) || !f3_legal ||
                              misaligned || sub_word);
        good_access = req && !bad_access;
        ram_load    = good_access && MemReadM_i && !is_mmio;
        ram_store   = good_access && MemWriteM_i && !is_mmio;
        mmio_load   = good_access && MemReadM_i && is_mmio;
        mmio_store  = good_access && MemWriteM_i && is_mmio;
        err_o       = bad_access && !rst_i;
    end

    // Store lane steering: replicate the narrow datum and enable the target lanes
    always_comb begin
        store_data = WriteDataM_i;
        byte_en    = 4'b1111;
        case (size)
            2'b00: begin
                store_data = {4{WriteDataM_i[7:0]}};
                byte_en    = 4'b0001 << ALUResultM_i[1:0];
            end
            2'b01: begin
                store_data = {2{WriteDataM_i[15:0]}};
                byte_en    = ALUResultM_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = WriteDataM_i;
                byte_en    = 4'b1111;
            end
        endcase
    end

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (ram_store && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[ram_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 samples the RAM, the last stage is the hold register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= mem[ram_idx];
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // Pick the addressed byte/half from the held word and extend it
    always_comb begin
        shifted  = hold >> {ALUResultM_i[1:0], 3'b000};
        load_ext = hold;
        case (Funct3M_i)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = hold;
        endcase
    end

    // Load handshake state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Load handshake next state and stall; the request cycle itself already stalls
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (ram_load) begin
                    stall = 1'b1;
                    if (RD_LAT == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 2'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        StallM_o = stall && !rst_i;
    end

    // MMIO read mux; unmapped word offsets read as zero
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            32'd0:   mmio_rdata = 32'(led_q);
            32'd4:   mmio_rdata = cycle_q;
            32'd8:   mmio_rdata = {miscount_q, 23'h0, sticky_q};
            default: mmio_rdata = 32'h0;
        endcase
    end

    // Load result: RAM data only in the completing cycle, MMIO data immediately
    always_comb begin
        ReadDataM_o = 32'h0;
        if (state == DONE) begin
            ReadDataM_o = load_ext;
        end else if (mmio_load) begin
            ReadDataM_o = mmio_rdata;
        end
    end

    // MMIO registers and error status; a counter write overrides the increment
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_q      <= '0;
            cycle_q    <= 32'h0;
            sticky_q   <= 1'b0;
            miscount_q <= 8'h0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (mmio_store && (mmio_off == 32'd0)) begin
                led_q <= WriteDataM_i[LED_W-1:0];
            end
            if (mmio_store && (mmio_off == 32'd4)) begin
                cycle_q <= WriteDataM_i;
            end
            if (mmio_store && (mmio_off == 32'd8)) begin
                sticky_q   <= 1'b0;
                miscount_q <= 8'h0;
            end else if (bad_access) begin
                sticky_q <= 1'b1;
                if (miscount_q != 8'hFF) begin
                    miscount_q <= miscount_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_dmem_subsys.sv
// tb_rv_dmem_subsys: drives two instances (read latency 2 and 3) with directed
// and random accesses and compares against a byte-addressed reference model.
module tb_rv_dmem_subsys;

    localparam logic [31:0] MMIO = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        rd_en  [2];
    logic        wr_en  [2];
    logic [2:0]  f3     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        stall  [2];
    logic [7:0]  led    [2];
    logic        err    [2];

    logic [7:0]  mdl_mem    [2][1024];
    logic [7:0]  mdl_led    [2];
    logic [31:0] cnt_val    [2];
    int          cnt_cyc    [2];
    logic [7:0]  mdl_mis    [2];
    logic        mdl_sticky [2];

    int cur_cycle = 0;
    int tests = 0;
    int fails = 0;

    // Free-running clock
    always #5 clk = ~clk;

    rv_dmem_subsys #(.ADDR_W(10), .RD_LAT(2), .MMIO_BASE(MMIO), .LED_W(8)) dut_lat2 (
        .clk_i(clk), .rst_i(rst[0]), .MemReadM_i(rd_en[0]), .MemWriteM_i(wr_en[0]),
        .Funct3M_i(f3[0]), .ALUResultM_i(addr[0]), .WriteDataM_i(wdata[0]),
        .ReadDataM_o(rdata[0]), .StallM_o(stall[0]), .led_o(led[0]), .err_o(err[0]));

    rv_dmem_subsys #(.ADDR_W(10), .RD_LAT(3), .MMIO_BASE(MMIO), .LED_W(8)) dut_lat3 (
        .clk_i(clk), .rst_i(rst[1]), .MemReadM_i(rd_en[1]), .MemWriteM_i(wr_en[1]),
        .Funct3M_i(f3[1]), .ALUResultM_i(addr[1]), .WriteDataM_i(wdata[1]),
        .ReadDataM_o(rdata[1]), .StallM_o(stall[1]), .led_o(led[1]), .err_o(err[1]));

    // Guard against a hung run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cur_cycle++;
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit mdl_bad(input bit rd, input bit wr, input logic [2:0] fn, input logic [31:0] a);
        int sz;
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b1;
        if (rd && !(fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (wr && !(fn inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        sz = 1 << fn[1:0];
        if ((int'(a[1:0]) % sz) != 0) return 1'b1;
        if ((a >= MMIO) && (sz != 4)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_counter(input int d, input int c);
        return cnt_val[d] + 32'(c - cnt_cyc[d]);
    endfunction

    function automatic logic [31:0] mdl_mmio_read(input int d, input logic [31:0] a, input int c);
        logic [31:0] off;
        off = a - MMIO;
        if (off == 32'd0) return {24'h0, mdl_led[d]};
        if (off == 32'd4) return mdl_counter(d, c);
        if (off == 32'd8) return {mdl_mis[d], 23'h0, mdl_sticky[d]};
        return 32'h0;
    endfunction

    function automatic logic [31:0] mdl_ram_read(input int d, input logic [31:0] a, input logic [2:0] fn);
        int sz;
        int idx;
        logic [31:0] v;
        sz  = 1 << fn[1:0];
        idx = int'(a[9:0]);
        v   = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mdl_mem[d][idx+i]) << (8*i));
        if (!fn[2] && (sz == 1) && v[7])  v = v | 32'hFFFF_FF00;
        if (!fn[2] && (sz == 2) && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic mdl_reset(input int d);
        mdl_led[d]    = 8'h0;
        cnt_val[d]    = 32'h0;
        cnt_cyc[d]    = cur_cycle;
        mdl_mis[d]    = 8'h0;
        mdl_sticky[d] = 1'b0;
    endtask

    task automatic set_idle(input int d);
        rd_en[d] = 1'b0;
        wr_en[d] = 1'b0;
        f3[d]    = 3'b0;
        addr[d]  = 32'h0;
        wdata[d] = 32'h0;
    endtask

    // Quiet cycles: nothing may be reported, stalled or returned
    task automatic idle(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            check_output("idle_err", err[d], 32'h0);
            check_output("idle_stall", stall[d], 32'h0);
            check_output("idle_rdata", rdata[d], 32'h0);
            check_output("idle_led", led[d], mdl_led[d]);
            step();
        end
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        set_idle(d);
        for (int k = 0; k < 2; k++) begin
            #1;
            check_output("reset_stall", stall[d], 32'h0);
            step();
        end
        rst[d] = 1'b0;
        mdl_reset(d);
    endtask

    // One core access held for as many cycles as the model says it stalls
    task automatic apply_stimulus(input int d, input bit rd, input bit wr, input logic [2:0] fn,
                                  input logic [31:0] a, input logic [31:0] dat, output logic [31:0] got);
        bit          bad;
        bit          mmio;
        int          n;
        int          sz;
        int          idx;
        logic [31:0] exp_rd;
        logic [31:0] off;
        bad    = mdl_bad(rd, wr, fn, a);
        mmio   = (a >= MMIO);
        n      = (rd && !bad && !mmio) ? lat_of(d) : 0;
        exp_rd = 32'h0;
        if (rd && !bad) exp_rd = mmio ? mdl_mmio_read(d, a, cur_cycle) : mdl_ram_read(d, a, fn);
        rd_en[d] = rd;
        wr_en[d] = wr;
        f3[d]    = fn;
        addr[d]  = a;
        wdata[d] = dat;
        got      = 32'h0;
        for (int k = 0; k <= n; k++) begin
            #1;
            check_output("err", err[d], 32'(bad));
            check_output("stall", stall[d], 32'(k < n));
            check_output("rdata", rdata[d], (k == n) ? exp_rd : 32'h0);
            check_output("led", led[d], mdl_led[d]);
            if (k == n) begin
                got = rdata[d];
                if (bad) begin
                    mdl_sticky[d] = 1'b1;
                    if (mdl_mis[d] != 8'hFF) mdl_mis[d] = mdl_mis[d] + 8'd1;
                end else if (wr && mmio) begin
                    off = a - MMIO;
                    if (off == 32'd0) mdl_led[d] = dat[7:0];
                    if (off == 32'd4) begin
                        cnt_val[d] = dat;
                        cnt_cyc[d] = cur_cycle + 1;
                    end
                    if (off == 32'd8) begin
                        mdl_mis[d]    = 8'h0;
                        mdl_sticky[d] = 1'b0;
                    end
                end else if (wr) begin
                    sz  = 1 << fn[1:0];
                    idx = int'(a[9:0]);
                    for (int i = 0; i < sz; i++) mdl_mem[d][idx+i] = dat[8*i +: 8];
                end
            end
            step();
        end
        set_idle(d);
    endtask

    // Directed plan followed by randomized traffic
    initial begin
        logic [31:0] g;
        int          lf [5];
        int          d;
        int          kind;
        logic [2:0]  fn;
        logic [31:0] a;
        bit          rd;
        lf = '{0, 1, 2, 4, 5};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            set_idle(i);
        end
        @(negedge clk);
        do_reset(0);
        do_reset(1);

        #1;
        check_output("reset_led", led[0], 32'h0);
        check_output("reset_err", err[0], 32'h0);
        check_output("reset_stall_out", stall[0], 32'h0);
        check_output("reset_rdata", rdata[0], 32'h0);
        step();
        apply_stimulus(0, 1, 0, 3'd2, MMIO + 32'd8, 32'h0, g);
        check_output("reset_status", g, 32'h0);
        apply_stimulus(0, 1, 0, 3'd2, MMIO + 32'd4, 32'h0, g);

        for (int dd = 0; dd < 2; dd++)
            for (int w = 0; w < 32; w++) apply_stimulus(dd, 0, 1, 3'd2, 32'(w * 4), 32'h0, g);

        apply_stimulus(0, 0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, g);
        apply_stimulus(0, 1, 0, 3'd2, 32'h10, 32'h0, g);
        check_output("lw_after_sw", g, 32'hDEAD_BEEF);

        apply_stimulus(0, 0, 1, 3'd2, 32'h10, 32'h0, g);
        apply_stimulus(0, 0, 1, 3'd0, 32'h11, 32'h7F, g);
        apply_stimulus(0, 1, 0, 3'd0, 32'h11, 32'h0, g);
        check_output("lb_pos", g, 32'h0000_007F);
        apply_stimulus(0, 0, 1, 3'd0, 32'h12, 32'h80, g);
        apply_stimulus(0, 1, 0, 3'd0, 32'h12, 32'h0, g);
        check_output("lb_neg", g, 32'hFFFF_FF80);
        apply_stimulus(0, 1, 0, 3'd4, 32'h12, 32'h0, g);
        check_output("lbu", g, 32'h0000_0080);
        apply_stimulus(0, 1, 0, 3'd2, 32'h10, 32'h0, g);
        check_output("lw_bytes", g, 32'h0080_7F00);

        apply_stimulus(0, 1, 0, 3'd1, 32'h13, 32'h0, g);
        check_output("lh_misaligned_data", g, 32'h0);
        idle(0, 1);
        apply_stimulus(0, 1, 0, 3'd2, MMIO + 32'd8, 32'h0, g);
        check_output("status_one_err", g, 32'h0100_0001);
        apply_stimulus(0, 0, 1, 3'd2, 32'h12, 32'hFFFF_FFFF, g);
        apply_stimulus(0, 1, 0, 3'd2, 32'h10, 32'h0, g);
        check_output("misaligned_sw_no_write", g, 32'h0080_7F00);
        apply_stimulus(0, 1, 0, 3'd2, MMIO + 32'd8, 32'h0, g);
        check_output("status_two_err", g, 32'h0200_0001);

        apply_stimulus(0, 0, 1, 3'd2, MMIO, 32'hA5, g);
        check_output("led_next_cycle", led[0], 32'hA5);
        idle(0, 1);
        apply_stimulus(0, 0, 1, 3'd2, MMIO + 32'd4, 32'h0, g);
        idle(0, 3);
        apply_stimulus(0, 1, 0, 3'd2, MMIO + 32'd4, 32'h0, g);
        check_output("counter_after_write", g, 32'd3);

        apply_stimulus(0, 0, 1, 3'd2, 32'h400, 32'h1234, g);
        apply_stimulus(0, 1, 0, 3'd2, 32'h0, 32'h0, g);
        check_output("alias_0x400", g, 32'h0000_1234);

        apply_stimulus(0, 0, 1, 3'd2, MMIO + 32'd8, 32'h0, g);
        apply_stimulus(0, 1, 0, 3'd2, MMIO + 32'd8, 32'h0, g);
        check_output("status_cleared", g, 32'h0);

        apply_stimulus(1, 0, 1, 3'd2, MMIO, 32'h5A, g);
        apply_stimulus(1, 0, 1, 3'd2, 32'h20, 32'hCAFE_F00D, g);
        rd_en[1] = 1'b1;
        f3[1]    = 3'd2;
        addr[1]  = 32'h20;
        #1;
        check_output("midwait_issue_stall", stall[1], 32'h1);
        step();
        #1;
        check_output("midwait_wait_stall", stall[1], 32'h1);
        step();
        rst[1] = 1'b1;
        #1;
        check_output("stall_in_reset", stall[1], 32'h0);
        check_output("err_in_reset", err[1], 32'h0);
        step();
        rst[1] = 1'b0;
        set_idle(1);
        mdl_reset(1);
        #1;
        check_output("led_after_reset", led[1], 32'h0);
        check_output("rdata_after_reset", rdata[1], 32'h0);
        step();
        apply_stimulus(1, 1, 0, 3'd2, 32'h20, 32'h0, g);
        check_output("lw_after_midwait_reset", g, 32'hCAFE_F00D);

        for (int n = 0; n < 400; n++) begin
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            a    = (32'($urandom_range(0, 7)) << 10) | 32'($urandom_range(0, 127));
            fn   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'(lf[$urandom_range(0, 4)]);
            if (kind <= 3) begin
                apply_stimulus(d, 1, 0, fn, a, $urandom, g);
            end else if (kind <= 6) begin
                if (fn > 3'd2) fn = ($urandom_range(0, 3) == 0) ? fn : 3'($urandom_range(0, 2));
                apply_stimulus(d, 0, 1, fn, a, $urandom, g);
            end else if (kind <= 8) begin
                rd = 1'($urandom_range(0, 1));
                fn = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
                apply_stimulus(d, rd, !rd, fn, MMIO + 32'($urandom_range(0, 19)), $urandom, g);
            end else begin
                apply_stimulus(d, 1, 1, fn, a, $urandom, g);
            end
            if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_dmem_subsys.md
Name: rv_dmem_subsys

Overview:
Parametrised data-memory subsystem for the pipelined RV32I core. It replaces the plain single-cycle RAM hookup at the M stage. It adds byte/halfword/word stores with byte enables, sign/zero-extended loads, and a synchronous RAM with configurable read latency that holds the pipeline through a stall handshake. It also adds a small memory-mapped I/O region with an LED register, a cycle counter and misaligned-access detection.

Parameters:
ADDR_W, 10, byte-address bits decoded for RAM; depth = 2^(ADDR_W-2) words.
RD_LAT, 1, RAM read latency in cycles; legal range 1..3.
MMIO_BASE, 32'h8000_0000, addresses >= MMIO_BASE select MMIO; all others select RAM.
LED_W, 8, width of the LED output register.

Ports:
clk_i  in  1  single clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
MemReadM_i  in  1  load request in M stage.
MemWriteM_i  in  1  store request in M stage.
Funct3M_i  in  3  access size/sign (RV32I load/store funct3).
ALUResultM_i  in  32  byte address.
WriteDataM_i  in  32  store data, right-aligned.
ReadDataM_o  out  32  extended load data.
StallM_o  out  1  hold F/D/E/M stages this cycle.
led_o  out  LED_W  MMIO LED register.
err_o  out  1  one-cycle pulse on an illegal or misaligned access.

Behaviour:
- Reset values (rst_i=1 at an edge): FSM=IDLE, led_o=0, cycle counter=0, err status=0, miscount=0, data hold register=0, err_o=0.
- StallM_o is forced to 0 while rst_i=1.
- RAM contents are not reset.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value counts as illegal.
- Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- Illegal or misaligned access:
  - The access is suppressed: no write, load returns 0, no stall.
  - err_o is high in the same cycle.
  - Sticky status bit 0 is set.
  - miscount increments and saturates at 255.
- MemReadM_i and MemWriteM_i both high counts as illegal.
- Stores:
  - Single cycle, never stall; written at the edge ending the request cycle.
  - Byte lanes are selected by addr[1:0].
  - SB replicates data[7:0] to all lanes; SH replicates data[15:0] to both halves.
  - Byte enables pick the lane(s).
- RAM address = addr[ADDR_W-1:2]. Upper address bits below MMIO_BASE are ignored, so accesses alias/wrap.
- RAM loads use the FSM IDLE -> WAIT -> DONE -> IDLE:
  - IDLE: a legal RAM load in cycle T issues the read. StallM_o=1 combinationally in cycle T. Go to WAIT with cnt=RD_LAT-1, or go directly to DONE if RD_LAT=1.
  - WAIT: StallM_o=1. cnt decrements; when cnt reaches 0, go to DONE.
  - DONE (cycle T+RD_LAT): StallM_o=0 and ReadDataM_o is valid (extracted from addr[1:0], then sign- or zero-extended). The outstanding request is not re-issued. Return to IDLE.
- The core holds all M inputs stable while StallM_o=1. A store in the cycle after DONE is legal.
- MMIO loads/stores: zero latency, no stall.
  - Word offsets: +0 LED (R/W, low LED_W bits); +4 cycle counter (R/W); +8 status (read {miscount[7:0], 23'b0, sticky}; any write clears both); other offsets read 0 and ignore writes.
  - MMIO is word-only. Sub-word MMIO access counts as illegal.
- Cycle counter increments every cycle and wraps at 2^32. An MMIO write in the same cycle wins over the increment.
- Reset mid-WAIT: the FSM goes to IDLE and the load is dropped.
- ReadDataM_o is 0 whenever no load is completing.

Test Plan:
- RD_LAT=2: SW 0xDEADBEEF @0x10, then LW @0x10 at cycle T -> StallM_o=1 in T and T+1; at T+2 StallM_o=0 and ReadDataM_o=0xDEADBEEF.
- SB 0x7F @0x11 over 0x00000000, then LB @0x11 -> 0x0000007F; SB 0x80 @0x12, then LB @0x12 -> 0xFFFFFF80, LBU @0x12 -> 0x00000080, LW @0x10 -> 0x00807F00.
- LH @0x13 -> err_o pulses for one cycle, ReadDataM_o=0, no stall, status read @MMIO_BASE+8 = 0x01000001; SW @0x12 -> no RAM change, miscount=2.
- SW 0xA5 @MMIO_BASE -> led_o=0xA5 on the next cycle; SW 0x0 @MMIO_BASE+4 then LW @MMIO_BASE+4 3 cycles later -> 3.
- rst_i asserted during WAIT (RD_LAT=3) -> StallM_o=0 immediately, FSM IDLE, led_o=0; a subsequent LW completes normally after 3 stall cycles.
- Access @0x400 with ADDR_W=10 aliases to @0x0: SW 0x1234 @0x400, LW @0x0 -> 0x00001234.
